top_hc595: RTL and testbench



---
 rtl/top_hc595.sv | 64 ++++++
 tb/tb_top_hc595.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/top_hc595.sv
// 8-bit serial-in / parallel-out shift register with output storage register (single-clock 74HC595).
// Define HC595_OE_TRISTATE_EN to float Qa..Qh when OUTPUTENABLE=1; otherwise they are driven 0.
module top_hc595 (
  input  logic SHIFTCLOCK,
  input  logic RESET,
  input  logic A,
  input  logic LATCHCLOCK,
  input  logic OUTPUTENABLE,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Qe,
  output logic Qf,
  output logic Qg,
  output logic Qh,
  output logic SQh
);

  logic [7:0] sr_reg;
  logic [7:0] st_reg;
  logic       lc_reg;
  logic       latch_fire;
  wire  [7:0] q_bus;

  // Only a sampled 0->1 transition of the strobe loads the storage register.
  assign latch_fire = LATCHCLOCK & ~lc_reg;

  // The storage register captures sr_reg before this edge's shift lands.
  always_ff @(posedge SHIFTCLOCK) begin
    if (RESET) begin
      sr_reg <= 8'h00;
      st_reg <= 8'h00;
      lc_reg <= 1'b0;
    end else begin
      sr_reg <= {sr_reg[6:0], A};
      lc_reg <= LATCHCLOCK;
      if (latch_fire) begin
        st_reg <= sr_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_out
`ifdef HC595_OE_TRISTATE_EN
      assign q_bus[gi] = OUTPUTENABLE ? 1'bz : st_reg[gi];
`else
      assign q_bus[gi] = ~OUTPUTENABLE & st_reg[gi];
`endif
    end
  endgenerate

  assign Qa  = q_bus[0];
  assign Qb  = q_bus[1];
  assign Qc  = q_bus[2];
  assign Qd  = q_bus[3];
  assign Qe  = q_bus[4];
  assign Qf  = q_bus[5];
  assign Qg  = q_bus[6];
  assign Qh  = q_bus[7];
  assign SQh = sr_reg[7];

endmodule

// File: tb/tb_top_hc595.sv
// Randomized self-checking bench for top_hc595 against a bit-history reference model.
// Directed scenarios cover reset, latch edge behaviour, output enable, and cascade output.
module tb_top_hc595;

  logic clk = 1'b0;
  logic rst, a, lc, oe;
  logic qa, qb, qc, qd, qe, qf, qg, qh, sqh;
  logic [7:0] q;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the serial bits accepted since reset (newest at the back) and the latched byte.
  bit         hist[$];
  logic [7:0] st_m;
  bit         lc_prev;

  always #5 clk = ~clk;

  top_hc595 dut (
    .SHIFTCLOCK  (clk),
    .RESET       (rst),
    .A           (a),
    .LATCHCLOCK  (lc),
    .OUTPUTENABLE(oe),
    .Qa          (qa),
    .Qb          (qb),
    .Qc          (qc),
    .Qd          (qd),
    .Qe          (qe),
    .Qf          (qf),
    .Qg          (qg),
    .Qh          (qh),
    .SQh         (sqh)
  );

  assign q = {qh, qg, qf, qe, qd, qc, qb, qa};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // The eight most recent serial bits form the shift register; older or missing bits are 0.
  function automatic logic [7:0] sr_m();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < hist.size(); i++) v[i] = hist[hist.size() - 1 - i];
    return v;
  endfunction

  function automatic logic [7:0] q_expect();
`ifdef HC595_OE_TRISTATE_EN
    return oe ? 8'bzzzz_zzzz : st_m;
`else
    return oe ? 8'h00 : st_m;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    logic [7:0] s;
    s = sr_m();
    check({tag, "_q"}, q, q_expect());
    check({tag, "_sqh"}, {7'b0, sqh}, {7'b0, s[7]});
  endtask

  task automatic step(input bit av, input bit lv, input bit rv);
    @(negedge clk);
    a = av; lc = lv; rst = rv;
    @(posedge clk);
    if (rv) begin
      hist.delete();
      st_m    = 8'h00;
      lc_prev = 1'b0;
    end else begin
      if (lv && !lc_prev) st_m = sr_m();
      lc_prev = lv;
      hist.push_back(av);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #1;
    $display("step rst=%0b a=%0b lc=%0b oe=%0b -> q=%b sqh=%0b", rv, av, lv, oe, q, sqh);
    check_outputs("step");
  endtask

  initial begin
    logic [7:0] pattern;
    logic [7:0] saved_q;
    logic       saved_sqh;
    rst = 1'b1; a = 1'b1; lc = 1'b0; oe = 1'b0;
    st_m = 8'h00; lc_prev = 1'b0;

    // Reset held two cycles with data high and a latch pulse present.
    step(1, 1, 1);
    step(1, 0, 1);
    check("reset_q", q, 8'h00);
    check("reset_sqh", {7'b0, sqh}, 8'h00);

    // Shift 1,0,1,1,0,0,1,0 with no latch, then latch while shifting a 0.
    pattern = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step(pattern[i], 0, 0);
    check("shift_noload_q", q, 8'h00);
    check("shift_sqh", {7'b0, sqh}, 8'h01);
    step(0, 1, 0);
    check("latch_q", q, 8'hB2);

    // Held-high strobe must not latch again.
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1, 0);
      check("level_hold_q", q, 8'hB2);
    end

    // Output enable acts immediately and leaves SQh alone.
    saved_sqh = sqh;
    oe = 1'b1;
    #1;
`ifdef HC595_OE_TRISTATE_EN
    check("oe_off_q", q, 8'bzzzz_zzzz);
`else
    check("oe_off_q", q, 8'h00);
`endif
    check("oe_off_sqh", {7'b0, sqh}, {7'b0, saved_sqh});
    oe = 1'b0;
    #1;
    check("oe_on_q", q, 8'hB2);

    // Drop then re-pulse: storage loads the current shift register.
    step(1, 0, 0);
    saved_q = sr_m();
    step(0, 1, 0);
    check("relatch_q", q, saved_q);
    step(0, 0, 0);

    // Reset mid-sequence discards partial data.
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 1, 0);
    check("midreset_q", q, 8'h07);
    check("midreset_sqh", {7'b0, sqh}, 8'h00);
    step(0, 0, 0);

    // Cascade: a lone 1 reaches SQh after eight edges and leaves on the ninth.
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0);
    check("cascade8_sqh", {7'b0, sqh}, 8'h01);
    step(0, 0, 0);
    check("cascade9_sqh", {7'b0, sqh}, 8'h00);

    // Random traffic, occasional reset, random enable.
    for (int i = 0; i < 400; i++) begin
      oe = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
